// File: rtl/multicycle_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : Decoding integer ALU for the RISKY execute stage. Add, sub, logic
//            and compare operations take one cycle. Shifts are iterative and
//            move at most SHIFT_PER_CYCLE bits per cycle.
// Revision : 1.0
// ============================================================================
module multicycle_alu #(
    parameter int XLEN            = 32,
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            sub_en,
    output logic            zero,
    output logic            lt,
    output logic            ltu,
    output logic            illegal
);

    localparam int         SH    = $clog2(XLEN);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [SH:0] SPC_C = SHIFT_PER_CYCLE[SH:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   result_q;
    logic              done_q;
    logic              sub_en_q;
    logic              zero_q;
    logic              lt_q;
    logic              ltu_q;
    logic              illegal_q;

    // Shift working state and the flags captured at start for the shift op
    logic [XLEN-1:0]   work_q;
    logic [SH:0]       cnt_q;
    logic              left_q;
    logic              sra_q;
    logic              pend_sub_q;
    logic              pend_zero_q;
    logic              pend_lt_q;
    logic              pend_ltu_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic w_is_r;
    logic w_is_i;
    logic w_is_b;
    logic w_f7_zero_sh;
    logic w_f7_alt_sh;

    assign w_is_r = (opcode == OP_R);
    assign w_is_i = (opcode == OP_I);
    assign w_is_b = (opcode == OP_B);

    // On RV64 the low funct7 bit of an immediate shift is shamt[5]
    assign w_f7_zero_sh = (XLEN == 64) ? (funct7[6:1] == 6'b000000)
                                       : (funct7 == 7'b0000000);
    assign w_f7_alt_sh  = (XLEN == 64) ? (funct7[6:1] == 6'b010000)
                                       : (funct7 == 7'b0100000);

    logic illegal_d;
    always_comb begin
        illegal_d = 1'b0;
        if (w_is_r) begin
            illegal_d = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000))
                     || ((funct7 == 7'b0100000)
                         && !((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (w_is_i) begin
            illegal_d = ((funct3 == 3'b001) && !w_f7_zero_sh)
                     || ((funct3 == 3'b101) && !(w_f7_zero_sh || w_f7_alt_sh));
        end else if (w_is_b) begin
            illegal_d = (funct3 == 3'b010) || (funct3 == 3'b011);
        end else begin
            illegal_d = 1'b1;
        end
    end

    logic          sub_d;
    logic          shift_d;
    logic          left_d;
    logic          sra_d;
    logic [SH-1:0] shamt_d;

    assign sub_d   = !illegal_d && (w_is_b
                                 || (w_is_r && (funct7[5] || funct3[1]))
                                 || (w_is_i && funct3[1]));
    assign left_d  = (funct3 == 3'b001);
    assign sra_d   = (funct3 == 3'b101) && funct7[5];
    assign shift_d = !illegal_d && (w_is_r || w_is_i)
                  && ((funct3 == 3'b001) || (funct3 == 3'b101));
    assign shamt_d = b[SH-1:0];

    // ------------------------------------------------------------------
    // Single-cycle arithmetic and flags
    // ------------------------------------------------------------------
    logic [XLEN:0] w_diff;
    logic          w_zero_raw;
    logic          w_lt_raw;
    logic          w_ltu_raw;

    assign w_diff     = {1'b0, a} - {1'b0, b};
    assign w_ltu_raw  = w_diff[XLEN];
    assign w_zero_raw = (w_diff[XLEN-1:0] == '0);
    assign w_lt_raw   = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : w_diff[XLEN-1];

    logic zero_d;
    logic lt_d;
    logic ltu_d;

    assign zero_d = sub_d && w_zero_raw;
    assign lt_d   = sub_d && w_lt_raw;
    assign ltu_d  = sub_d && w_ltu_raw;

    logic [XLEN-1:0] res_d;
    always_comb begin
        res_d = '0;
        if (w_is_b) begin
            res_d = w_diff[XLEN-1:0];
        end else begin
            case (funct3)
                3'b000:  res_d = sub_d ? w_diff[XLEN-1:0] : (a + b);
                3'b010:  res_d = {{(XLEN-1){1'b0}}, w_lt_raw};
                3'b011:  res_d = {{(XLEN-1){1'b0}}, w_ltu_raw};
                3'b100:  res_d = a ^ b;
                3'b110:  res_d = a | b;
                3'b111:  res_d = a & b;
                // Shifts that complete immediately (shamt == 0) pass a through
                default: res_d = a;
            endcase
        end
        if (illegal_d) begin
            res_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Iterative shift step
    // ------------------------------------------------------------------
    logic [SH:0]     w_step;
    logic [XLEN-1:0] w_shifted;

    assign w_step = (cnt_q > SPC_C) ? SPC_C : cnt_q;

    always_comb begin
        w_shifted = work_q;
        if (left_q) begin
            w_shifted = work_q << w_step;
        end else if (sra_q) begin
            w_shifted = $signed(work_q) >>> w_step;
        end else begin
            w_shifted = work_q >> w_step;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            done_q      <= 1'b0;
            sub_en_q    <= 1'b0;
            zero_q      <= 1'b0;
            lt_q        <= 1'b0;
            ltu_q       <= 1'b0;
            illegal_q   <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            sra_q       <= 1'b0;
            pend_sub_q  <= 1'b0;
            pend_zero_q <= 1'b0;
            pend_lt_q   <= 1'b0;
            pend_ltu_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (shift_d && (shamt_d != '0)) begin
                            work_q      <= a;
                            cnt_q       <= {1'b0, shamt_d};
                            left_q      <= left_d;
                            sra_q       <= sra_d;
                            pend_sub_q  <= sub_d;
                            pend_zero_q <= zero_d;
                            pend_lt_q   <= lt_d;
                            pend_ltu_q  <= ltu_d;
                            state_q     <= S_SHIFT;
                        end else begin
                            result_q  <= res_d;
                            sub_en_q  <= sub_d;
                            zero_q    <= zero_d;
                            lt_q      <= lt_d;
                            ltu_q     <= ltu_d;
                            illegal_q <= illegal_d;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    work_q <= w_shifted;
                    cnt_q  <= cnt_q - w_step;
                    if (cnt_q == w_step) begin
                        result_q  <= w_shifted;
                        sub_en_q  <= pend_sub_q;
                        zero_q    <= pend_zero_q;
                        lt_q      <= pend_lt_q;
                        ltu_q     <= pend_ltu_q;
                        illegal_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign result  = result_q;
    assign sub_en  = sub_en_q;
    assign zero    = zero_q;
    assign lt      = lt_q;
    assign ltu     = ltu_q;
    assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu
// Brief    : Directed bench for multicycle_alu, one instance stepping one bit
//            per shift cycle and one stepping four.
// Revision : 1.0
// ============================================================================
module tb_multicycle_alu;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        busy1, done1, sub1, zero1, lt1, ltu1, ill1;
    logic        busy4, done4, sub4, zero4, lt4, ltu4, ill4;
    logic [31:0] result1, result4;
    logic [38:0] outs1, outs4;
    logic [4:0]  flags1;

    assign outs1  = {busy1, done1, result1, sub1, zero1, lt1, ltu1, ill1};
    assign outs4  = {busy4, done4, result4, sub4, zero4, lt4, ltu4, ill4};
    assign flags1 = {sub1, zero1, lt1, ltu1, ill1};

    always #5 clk = ~clk;

    multicycle_alu #(.XLEN(32), .SHIFT_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .a(a), .b(b), .busy(busy1), .done(done1),
        .result(result1), .sub_en(sub1), .zero(zero1), .lt(lt1), .ltu(ltu1),
        .illegal(ill1)
    );

    multicycle_alu #(.XLEN(32), .SHIFT_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .a(a), .b(b), .busy(busy4), .done(done4),
        .result(result4), .sub_en(sub4), .zero(zero4), .lt(lt4), .ltu(ltu4),
        .illegal(ill4)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int lat1, lat4, nd1, nd4, nb1;
    logic [38:0] snap1, snap4;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, then observe both instances for 'window' cycles (cycle 1 is
    // the cycle after the start edge). At cycle 'poke' a competing ADD start is
    // driven; at cycle 'rst_at' reset is asserted for one edge.
    task automatic op(input logic [6:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] aa,
                      input logic [31:0] bb, input int window,
                      input int poke, input int rst_at);
        @(negedge clk);
        opcode = opc; funct3 = f3; funct7 = f7; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        lat1 = 0; lat4 = 0; nd1 = 0; nd4 = 0; nb1 = 0;
        snap1 = '1; snap4 = '1;
        for (int c = 1; c <= window; c++) begin
            if (done1) begin nd1++; if (lat1 == 0) lat1 = c; end
            if (done4) begin nd4++; if (lat4 == 0) lat4 = c; end
            if (busy1) nb1++;
            if (c == rst_at + 1) begin snap1 = outs1; snap4 = outs4; end
            @(negedge clk);
            start = (c == poke);
            if (c == poke) begin
                opcode = OP_R; funct3 = 3'b000; funct7 = 7'b0; a = 32'd7; b = 32'd8;
            end
            rst = (c == rst_at);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_outs1", 64'(outs1), 64'd0);
        check("reset_outs4", 64'(outs4), 64'd0);

        // R SUB 5-7
        op(OP_R, 3'b000, 7'b0100000, 32'd5, 32'd7, 3, 0, 0);
        check("sub_lat", 64'(lat1), 64'd1);
        check("sub_ndone", 64'(nd1), 64'd1);
        check("sub_busy", 64'(nb1), 64'd1);
        check("sub_res", 64'(result1), 64'hFFFF_FFFE);
        check("sub_flags", 64'(flags1), 64'b10110);

        // Branch equal operands
        op(OP_B, 3'b000, 7'b0, 32'h8000_0000, 32'h8000_0000, 3, 0, 0);
        check("beq_lat", 64'(lat1), 64'd1);
        check("beq_res", 64'(result1), 64'd0);
        check("beq_flags", 64'(flags1), 64'b11000);

        // Branch signed overflow case
        op(OP_B, 3'b000, 7'b0, 32'h8000_0000, 32'd1, 3, 0, 0);
        check("blt_res", 64'(result1), 64'h7FFF_FFFF);
        check("blt_flags", 64'(flags1), 64'b10100);

        // SRAI by 4
        op(OP_I, 3'b101, 7'b0100000, 32'h8000_0010, 32'h0000_0404, 8, 0, 0);
        check("srai_lat1", 64'(lat1), 64'd5);
        check("srai_lat4", 64'(lat4), 64'd2);
        check("srai_busy", 64'(nb1), 64'd5);
        check("srai_res1", 64'(result1), 64'hF800_0001);
        check("srai_res4", 64'(result4), 64'hF800_0001);
        check("srai_flags", 64'(flags1), 64'b00000);

        // SLL by 0
        op(OP_R, 3'b001, 7'b0, 32'h1234_5678, 32'd0, 3, 0, 0);
        check("sll0_lat1", 64'(lat1), 64'd1);
        check("sll0_lat4", 64'(lat4), 64'd1);
        check("sll0_res", 64'(result1), 64'h1234_5678);

        // SLL by 31
        op(OP_R, 3'b001, 7'b0, 32'd1, 32'd31, 34, 0, 0);
        check("sll31_lat1", 64'(lat1), 64'd32);
        check("sll31_lat4", 64'(lat4), 64'd9);
        check("sll31_res1", 64'(result1), 64'h8000_0000);
        check("sll31_res4", 64'(result4), 64'h8000_0000);

        // XOR and SLT
        op(OP_R, 3'b100, 7'b0, 32'h0000_F0F0, 32'h0000_0FF0, 3, 0, 0);
        check("xor_res", 64'(result1), 64'h0000_FF00);
        check("xor_flags", 64'(flags1), 64'b00000);
        op(OP_R, 3'b010, 7'b0, 32'hFFFF_FFFF, 32'd1, 3, 0, 0);
        check("slt_res", 64'(result1), 64'd1);
        check("slt_flags", 64'(flags1), 64'b10100);

        // Illegal encodings
        op(OP_R, 3'b000, 7'b0000001, 32'd5, 32'd3, 3, 0, 0);
        check("ill_f7_lat", 64'(lat1), 64'd1);
        check("ill_f7_res", 64'(result1), 64'd0);
        check("ill_f7_flags", 64'(flags1), 64'b00001);
        op(OP_R, 3'b100, 7'b0, 32'h0000_F0F0, 32'h0000_0FF0, 3, 0, 0);
        op(7'b0000011, 3'b000, 7'b0, 32'd5, 32'd3, 3, 0, 0);
        check("ill_op_lat", 64'(lat1), 64'd1);
        check("ill_op_res", 64'(result1), 64'd0);
        check("ill_op_flags", 64'(flags1), 64'b00001);
        op(OP_R, 3'b100, 7'b0, 32'h0000_F0F0, 32'h0000_0FF0, 3, 0, 0);
        op(OP_B, 3'b010, 7'b0, 32'd5, 32'd5, 3, 0, 0);
        check("ill_br_lat", 64'(lat1), 64'd1);
        check("ill_br_res", 64'(result1), 64'd0);
        check("ill_br_flags", 64'(flags1), 64'b00001);

        // Start pulsed while busy on a 20-bit shift is ignored
        op(OP_R, 3'b001, 7'b0, 32'd1, 32'd20, 26, 3, 0);
        check("ign_ndone1", 64'(nd1), 64'd1);
        check("ign_ndone4", 64'(nd4), 64'd1);
        check("ign_lat1", 64'(lat1), 64'd21);
        check("ign_lat4", 64'(lat4), 64'd6);
        check("ign_res", 64'(result1), 64'h0010_0000);

        // Reset in cycle 3 of a long shift
        op(OP_R, 3'b001, 7'b0, 32'd3, 32'd20, 26, 0, 3);
        check("rst_outs1", 64'(snap1), 64'd0);
        check("rst_outs4", 64'(snap4), 64'd0);
        check("rst_ndone1", 64'(nd1), 64'd0);
        check("rst_ndone4", 64'(nd4), 64'd0);

        // ADDI 2 + (-3)
        op(OP_I, 3'b000, 7'b1111111, 32'd2, 32'hFFFF_FFFD, 3, 0, 0);
        check("addi_lat", 64'(lat1), 64'd1);
        check("addi_res", 64'(result1), 64'hFFFF_FFFF);
        check("addi_flags", 64'(flags1), 64'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
